// File: rtl/hdmi_timing_monitor_pkg.sv
// Shared definitions for hdmi_timing_monitor: state encoding, field widths and
// a saturating increment used when closing the open line at publish time.
package hdmi_timing_monitor_pkg;

  // Measurement FSM: wait for the first vsync fall, then measure whole frames.
  typedef enum logic {
    StWait,
    StMeasure
  } state_e;

  localparam int unsigned GeomW     = 12;
  localparam int unsigned FrameCntW = 16;
  localparam int unsigned ErrCntW   = 8;
  // Wide enough for LOCK_FRAMES up to 15.
  localparam int unsigned MatchW    = 4;

  localparam logic [GeomW-1:0] GeomMax = '1;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [GeomW-1:0] sat_inc(input logic [GeomW-1:0] val);
    return (val == GeomMax) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/hdmi_sat_counter.sv
// Saturating up-counter. A clear takes priority; clearing and incrementing on
// the same clock loads 1, so the clearing clock counts as the first of the new
// interval.
module hdmi_sat_counter #(
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] Max = '1;

  logic [Width-1:0] count_q;

  // Clear-to-{0,1}, otherwise increment until all ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= {{(Width-1){1'b0}}, inc};
    end else if (inc && (count_q != Max)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hdmi_timing_monitor.sv
// Video geometry monitor in the hdmi_clk domain. Measures active width/height
// and total clocks/lines per frame from hsync/vsync/rgb_valid, publishes them on
// every vsync fall, and tracks lock over consecutive identical frames.
// Optional mismatch counter enabled by defining HDMI_TIMING_ERRCNT_EN; without
// it err_count is tied to zero.
module hdmi_timing_monitor
  import hdmi_timing_monitor_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 3,
  parameter int unsigned TIMEOUT     = 4194304
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rgb_valid,
  input  logic                 hsync,
  input  logic                 vsync,
  output logic [GeomW-1:0]     width,
  output logic [GeomW-1:0]     height,
  output logic [GeomW-1:0]     htotal,
  output logic [GeomW-1:0]     vtotal,
  output logic                 locked,
  output logic                 frame_strobe,
  output logic [FrameCntW-1:0] frame_count,
  output logic [ErrCntW-1:0]   err_count
);

  localparam int unsigned       TimerW     = $clog2(TIMEOUT + 1);
  localparam logic [TimerW-1:0] TimeoutVal = TimerW'(TIMEOUT);
  localparam logic [MatchW-1:0] LockCnt    = MatchW'(LOCK_FRAMES);

  state_e               state_q;
  logic                 prev_h_q, prev_v_q;
  logic [TimerW-1:0]    timer_q;
  logic [MatchW-1:0]    match_cnt_q, match_cnt_d;
  logic [GeomW-1:0]     cur_w_q;
  logic [GeomW-1:0]     width_q, height_q, htotal_q, vtotal_q;
  logic                 locked_q, strobe_q;
  logic [FrameCntW-1:0] frame_count_q;

  logic [GeomW-1:0] line_clk, line_act, cur_h, cur_v;
  logic [GeomW-1:0] pub_w, pub_h, pub_ht, pub_v;
  logic             hfall, vfall, measuring, close_line, act_nz;
  logic             publish, timeout, match;

  assign hfall      = prev_h_q & ~hsync;
  assign vfall      = prev_v_q & ~vsync;
  assign measuring  = (state_q == StMeasure);
  // A vfall closes the open line even without an hfall; coincident falls close once.
  assign close_line = measuring & (hfall | vfall);
  assign act_nz     = (line_act != '0);
  assign publish    = measuring & vfall;
  // A vfall on the expiry clock counts as signal presence.
  assign timeout    = ~vfall & (timer_q == TimeoutVal);

  // In WAIT the counters only get primed by the vfall that starts measuring.
  hdmi_sat_counter #(
    .Width(GeomW)
  ) u_line_clk (
    .clk  (clk),
    .reset(reset),
    .clr  (vfall | close_line),
    .inc  (vfall | measuring),
    .count(line_clk)
  );

  // rgb_valid on a line-closing clock belongs to the new line.
  hdmi_sat_counter #(
    .Width(GeomW)
  ) u_line_act (
    .clk  (clk),
    .reset(reset),
    .clr  (vfall | close_line),
    .inc  (rgb_valid & (vfall | measuring)),
    .count(line_act)
  );

  // Frame-level line counters restart at 0 on vfall; the closing line is folded
  // into the published values combinationally instead.
  hdmi_sat_counter #(
    .Width(GeomW)
  ) u_cur_h (
    .clk  (clk),
    .reset(reset),
    .clr  (vfall),
    .inc  (measuring & hfall & ~vfall & act_nz),
    .count(cur_h)
  );

  hdmi_sat_counter #(
    .Width(GeomW)
  ) u_cur_v (
    .clk  (clk),
    .reset(reset),
    .clr  (vfall),
    .inc  (measuring & hfall & ~vfall),
    .count(cur_v)
  );

  // Values of the frame as if the open line had just been closed.
  always_comb begin
    pub_w  = act_nz ? line_act : cur_w_q;
    pub_h  = act_nz ? sat_inc(cur_h) : cur_h;
    pub_ht = line_clk;
    pub_v  = sat_inc(cur_v);
  end

  // Compare against the last published frame and advance the match run.
  always_comb begin
    match = (pub_w == width_q) && (pub_h == height_q) && (pub_ht == htotal_q) &&
            (pub_v == vtotal_q) && (pub_h != '0);
    match_cnt_d = match_cnt_q;
    if (match) begin
      if (match_cnt_q < LockCnt) begin
        match_cnt_d = match_cnt_q + 1'b1;
      end
    end else begin
      match_cnt_d = '0;
    end
  end

  // Edge history, timeout timer, FSM and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StWait;
      prev_h_q      <= 1'b1;
      prev_v_q      <= 1'b1;
      timer_q       <= '0;
      cur_w_q       <= '0;
      width_q       <= '0;
      height_q      <= '0;
      htotal_q      <= '0;
      vtotal_q      <= '0;
      locked_q      <= 1'b0;
      strobe_q      <= 1'b0;
      frame_count_q <= '0;
      match_cnt_q   <= '0;
    end else begin
      prev_h_q <= hsync;
      prev_v_q <= vsync;
      strobe_q <= publish;

      if (vfall || timeout) begin
        timer_q <= '0;
      end else begin
        timer_q <= timer_q + 1'b1;
      end

      // Width of the most recent active line; blank lines keep it.
      if (vfall) begin
        cur_w_q <= '0;
      end else if (close_line && act_nz) begin
        cur_w_q <= line_act;
      end

      if (timeout) begin
        // Signal lost: forget geometry but keep the published frame count.
        state_q     <= StWait;
        match_cnt_q <= '0;
        locked_q    <= 1'b0;
        width_q     <= '0;
        height_q    <= '0;
        htotal_q    <= '0;
        vtotal_q    <= '0;
      end else begin
        unique case (state_q)
          StWait: begin
            if (vfall) begin
              state_q <= StMeasure;
            end
          end
          StMeasure: begin
            if (publish) begin
              width_q       <= pub_w;
              height_q      <= pub_h;
              htotal_q      <= pub_ht;
              vtotal_q      <= pub_v;
              frame_count_q <= frame_count_q + 1'b1;
              match_cnt_q   <= match_cnt_d;
              locked_q      <= (match_cnt_d == LockCnt);
            end
          end
          default: state_q <= StWait;
        endcase
      end
    end
  end

`ifdef HDMI_TIMING_ERRCNT_EN
  logic [ErrCntW-1:0] err_q;

  // Count published mismatches that break an established lock; only reset clears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= '0;
    end else if (publish && !match && locked_q && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  assign width        = width_q;
  assign height       = height_q;
  assign htotal       = htotal_q;
  assign vtotal       = vtotal_q;
  assign locked       = locked_q;
  assign frame_strobe = strobe_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_hdmi_timing_monitor.sv
// Self-checking bench for hdmi_timing_monitor. Frames are described line by
// line (length, active pixels, whether the line starts with an hsync fall);
// the reference model derives the expected geometry of each frame from that
// description and applies the publish/lock/timeout rules at frame level.
module tb_hdmi_timing_monitor;

  localparam int unsigned LockFrames  = 3;
  localparam int unsigned TimeoutClks = 8000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rgb_valid, hsync, vsync;
  logic [11:0] width, height, htotal, vtotal;
  logic        locked, frame_strobe;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  hdmi_timing_monitor #(
    .LOCK_FRAMES(LockFrames),
    .TIMEOUT    (TimeoutClks)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rgb_valid   (rgb_valid),
    .hsync       (hsync),
    .vsync       (vsync),
    .width       (width),
    .height      (height),
    .htotal      (htotal),
    .vtotal      (vtotal),
    .locked      (locked),
    .frame_strobe(frame_strobe),
    .frame_count (frame_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Frame description
  int fr_len[16];
  int fr_act[16];
  bit fr_hf[16];
  int fr_n;
  int g_len, g_nl, g_act, g_fa, g_la;

  // Reference model state
  logic [11:0] m_w, m_h, m_ht, m_vt;
  logic [11:0] p_w, p_h, p_ht, p_vt;
  logic [15:0] m_fc;
  logic [7:0]  m_err;
  int          m_match;
  bit          m_locked, m_measuring, m_pub;
  int          since;
  bit          tb_prev_v;

  logic [73:0] obs_pub, exp_pub, zero74;
  logic        obs_next;
  logic [74:0] obs_snap, exp_snap;

  task automatic model_reset();
    m_w = '0; m_h = '0; m_ht = '0; m_vt = '0;
    p_w = '0; p_h = '0; p_ht = '0; p_vt = '0;
    m_fc = '0; m_err = '0; m_match = 0; m_locked = 0; m_measuring = 0; m_pub = 0;
    since = 0; tb_prev_v = 1;
  endtask

  task automatic model_timeout();
    m_measuring = 0;
    m_w = '0; m_h = '0; m_ht = '0; m_vt = '0;
    m_match = 0; m_locked = 0;
  endtask

  // Frame boundary: publish the previously driven frame if measuring.
  task automatic model_vfall();
    bit match;
    if (!m_measuring) begin
      m_measuring = 1;
      m_pub = 0;
    end else begin
      match = (p_w == m_w) && (p_h == m_h) && (p_ht == m_ht) && (p_vt == m_vt) && (p_h != 0);
`ifdef HDMI_TIMING_ERRCNT_EN
      if (!match && m_locked && m_err != 8'd255) m_err = m_err + 8'd1;
`endif
      if (match) begin
        if (m_match < int'(LockFrames)) m_match++;
      end else begin
        m_match = 0;
      end
      m_locked = (m_match == int'(LockFrames));
      m_w = p_w; m_h = p_h; m_ht = p_ht; m_vt = p_vt;
      m_fc = m_fc + 16'd1;
      m_pub = 1;
    end
    exp_pub = {m_w, m_h, m_ht, m_vt, m_locked, m_fc, m_err, m_pub};
  endtask

  // Geometry of the frame just driven, straight from its line list.
  task automatic frame_geom();
    int h, w, ht, vt;
    h = 0; w = 0;
    for (int i = 0; i < fr_n; i++) begin
      if (fr_act[i] > 0) begin
        h++;
        w = fr_act[i];
      end
    end
    ht = (fr_len[fr_n-1] > 4095) ? 4095 : fr_len[fr_n-1];
    vt = (fr_n > 4095) ? 4095 : fr_n;
    p_w = 12'(w); p_h = 12'(h); p_ht = 12'(ht); p_vt = 12'(vt);
  endtask

  // One clock: drive at the falling edge, track vsync history and timeout.
  task automatic step(input logic h, input logic v, input logic r);
    hsync = h; vsync = v; rgb_valid = r;
    @(posedge clk);
    if (tb_prev_v && !v) begin
      since = 0;
    end else if (since == int'(TimeoutClks)) begin
      since = 0;
      model_timeout();
    end else begin
      since++;
    end
    tb_prev_v = v;
    @(negedge clk);
  endtask

  // Drive the described frame (vsync low for line 0). max_clk >= 0 aborts early.
  task automatic drive_frame(input int max_clk);
    int k;
    k = 0;
    for (int i = 0; i < fr_n; i++) begin
      for (int c = 0; c < fr_len[i]; c++) begin
        if (max_clk >= 0 && k == max_clk) return;
        step((fr_hf[i] && c < 2) ? 1'b0 : 1'b1, (i == 0) ? 1'b0 : 1'b1,
             (c >= 1 && c <= fr_act[i]) ? 1'b1 : 1'b0);
        if (i == 0 && c == 0) begin
          obs_pub = {width, height, htotal, vtotal, locked, frame_count, err_count,
                     frame_strobe};
          model_vfall();
        end
        if (i == 0 && c == 1) obs_next = frame_strobe;
        k++;
      end
    end
    frame_geom();
    obs_snap = {obs_pub, obs_next};
    exp_snap = {exp_pub, 1'b0};
  endtask

  task automatic gen_geom();
    g_len = int'($urandom_range(30, 70));
    g_nl  = int'($urandom_range(6, 10));
    g_act = int'($urandom_range(8, g_len - 4));
    g_fa  = 2;
    g_la  = g_nl - 2;
  endtask

  task automatic build_base();
    fr_n = g_nl;
    for (int i = 0; i < fr_n; i++) begin
      fr_len[i] = g_len;
      fr_hf[i]  = 1;
      fr_act[i] = (i >= g_fa && i <= g_la) ? g_act : 0;
    end
  endtask

  task automatic test_reset();
    reset = 1; hsync = 1; vsync = 1; rgb_valid = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({width, height, htotal, vtotal, locked, frame_count, err_count, frame_strobe}
        !== zero74) begin
      $display("FAIL reset_values: got %h expected 0", {width, height, htotal, vtotal,
               locked, frame_count, err_count, frame_strobe});
    end else n_pass++;
    reset = 0;
    model_reset();
  endtask

  task automatic test_lock();
    gen_geom();
    build_base();
    for (int k = 0; k < 6; k++) begin
      drive_frame(-1);
      n_checks++;
      if (obs_snap !== exp_snap)
        $display("FAIL lock_frame%0d: got %h expected %h", k, obs_snap, exp_snap);
      else n_pass++;
    end
    n_checks++;
    if (locked !== 1'b1) $display("FAIL lock_after_5_vfalls: got %b expected 1", locked);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    build_base();
    fr_act[g_la] = 0;
    drive_frame(-1);
    n_checks++;
    if (obs_snap !== exp_snap)
      $display("FAIL mismatch_short: got %h expected %h", obs_snap, exp_snap);
    else n_pass++;
    build_base();
    for (int k = 0; k < 5; k++) begin
      drive_frame(-1);
      n_checks++;
      if (obs_snap !== exp_snap)
        $display("FAIL mismatch_relock%0d: got %h expected %h", k, obs_snap, exp_snap);
      else n_pass++;
    end
    n_checks++;
    if (locked !== 1'b1) $display("FAIL relock: got %b expected 1", locked);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int   strobes;
    logic mid_obs;
    bit   mid_exp;
    strobes = 0; mid_obs = 1'bx; mid_exp = 0;
    for (int c = 0; c < int'(TimeoutClks) + 100; c++) begin
      step(((c % 64) < 2) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      if (frame_strobe) strobes++;
      if (since == int'(TimeoutClks) - 50) begin
        mid_obs = locked;
        mid_exp = m_locked;
      end
    end
    n_checks++;
    if (mid_obs !== mid_exp)
      $display("FAIL timeout_early: got %b expected %b", mid_obs, mid_exp);
    else n_pass++;
    n_checks++;
    if (strobes != 0) $display("FAIL timeout_strobe: got %0d strobes expected 0", strobes);
    else n_pass++;
    n_checks++;
    if ({width, height, htotal, vtotal, locked, frame_count, err_count} !==
        {m_w, m_h, m_ht, m_vt, m_locked, m_fc, m_err})
      $display("FAIL timeout_outputs: got %h expected %h",
               {width, height, htotal, vtotal, locked, frame_count, err_count},
               {m_w, m_h, m_ht, m_vt, m_locked, m_fc, m_err});
    else n_pass++;
    build_base();
    for (int k = 0; k < 5; k++) begin
      drive_frame(-1);
      n_checks++;
      if (obs_snap !== exp_snap)
        $display("FAIL timeout_resume%0d: got %h expected %h", k, obs_snap, exp_snap);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    fr_n = 3;
    fr_len[0] = 50;   fr_act[0] = 0;  fr_hf[0] = 1;
    fr_len[1] = 60;   fr_act[1] = 20; fr_hf[1] = 1;
    fr_len[2] = 5000; fr_act[2] = 0;  fr_hf[2] = 1;
    drive_frame(-1);
    build_base();
    drive_frame(-1);
    n_checks++;
    if (obs_snap !== exp_snap)
      $display("FAIL sat_frame: got %h expected %h", obs_snap, exp_snap);
    else n_pass++;
    n_checks++;
    if (htotal !== 12'd4095) $display("FAIL sat_htotal: got %0d expected 4095", htotal);
    else n_pass++;
  endtask

  task automatic test_noncoincident();
    build_base();
    fr_len[fr_n] = 100; fr_act[fr_n] = 0; fr_hf[fr_n] = 1;
    fr_n++;
    drive_frame(-1);
    n_checks++;
    if (obs_snap !== exp_snap)
      $display("FAIL noncoin_a: got %h expected %h", obs_snap, exp_snap);
    else n_pass++;
    build_base();
    fr_hf[0] = 0;
    drive_frame(-1);
    n_checks++;
    if ({htotal, vtotal} !== {12'd100, 12'(g_nl + 1)})
      $display("FAIL noncoin_partial: got %0d/%0d expected 100/%0d", htotal, vtotal, g_nl + 1);
    else n_pass++;
    build_base();
    drive_frame(-1);
    n_checks++;
    if (obs_snap !== exp_snap)
      $display("FAIL noncoin_b: got %h expected %h", obs_snap, exp_snap);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    build_base();
    for (int k = 0; k < 5; k++) drive_frame(-1);
    n_checks++;
    if (locked !== 1'b1) $display("FAIL prereset_lock: got %b expected 1", locked);
    else n_pass++;
    drive_frame(g_len + 10);
    #2 reset = 1;
    #1;
    n_checks++;
    if ({width, height, htotal, vtotal, locked, frame_count, err_count, frame_strobe}
        !== zero74) begin
      $display("FAIL async_reset: got %h expected 0", {width, height, htotal, vtotal,
               locked, frame_count, err_count, frame_strobe});
    end else n_pass++;
    repeat (2) @(negedge clk);
    reset = 0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      drive_frame(-1);
      n_checks++;
      if (obs_snap !== exp_snap)
        $display("FAIL postreset%0d: got %h expected %h", k, obs_snap, exp_snap);
      else n_pass++;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    zero74 = '0;
    model_reset();
    test_reset();
    test_lock();
    test_mismatch();
    test_timeout();
    test_saturation();
    test_noncoincident();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
